// File: rtl/spi_cfg_pkg.sv
// Shared constants, register map and FSM states
// for the SPI configuration write sequencer.
package spi_cfg_pkg;

  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;
  localparam int FRAME_W = 16;

  localparam logic WRITE_BIT = 1'b1;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'd0;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'd1;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'd2;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'd3;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'd4;
  localparam logic [ADDR_W-1:0] MAX_ADDRESS     = 7'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

endpackage

// File: rtl/spi_cfg_write_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: first
// valid request after the pointer wins.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW      = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);

  always_comb begin
    int j;
    logic found;
    j     = 0;
    found = 1'b0;
    gnt   = '0;
    idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
    any = found;
  end

endmodule

// File: rtl/spi_cfg_write_sequencer.sv
// Round-robin arbiter in front of a write-only
// 16-bit SPI mode-0 configuration link.
module spi_cfg_write_sequencer
  import spi_cfg_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      nCS,
  output logic                      SCLK,
  output logic                      COPI
);

  localparam int IW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MAXC = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [CW-1:0] DIV_END = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] GAP_END = CW'(CS_GAP - 1);

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [3:0]           bit_cnt;
  logic [FRAME_W-1:0]   shreg;
  logic [IW-1:0]        ptr;
  logic [NUM_REQ-1:0]   gnt;
  logic [IW-1:0]        gnt_idx;
  logic                 any;
  logic [FRAME_W-1:0]   frame;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (any)
  );

  always_comb begin
    frame = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        frame = {WRITE_BIT,
                 req_addr[ADDR_W*i +: ADDR_W],
                 req_data[DATA_W*i +: DATA_W]};
      end
    end
  end

  // COPI is the MSB of the shift register, so it
  // only moves when the register shifts on SCLK fall.
  assign COPI = shreg[FRAME_W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      ptr        <= IW'(NUM_REQ - 1);
      req_ready  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      nCS        <= 1'b1;
      SCLK       <= 1'b0;
    end else begin
      req_ready  <= '0;
      frame_done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (enable && any) begin
            shreg     <= frame;
            ptr       <= gnt_idx;
            req_ready <= gnt;
            nCS       <= 1'b0;
            busy      <= 1'b1;
            cnt       <= '0;
            bit_cnt   <= '0;
            state     <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (cnt == DIV_END) begin
            cnt   <= '0;
            SCLK  <= 1'b1;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (cnt != DIV_END) begin
            cnt <= cnt + 1'b1;
          end else begin
            cnt <= '0;
            if (!SCLK) begin
              SCLK <= 1'b1;
            end else begin
              SCLK <= 1'b0;
              if (bit_cnt == 4'd15) begin
                state <= S_HOLD;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
              end
            end
          end
        end
        S_HOLD: begin
          if (cnt == DIV_END) begin
            cnt        <= '0;
            nCS        <= 1'b1;
            frame_done <= 1'b1;
            state      <= S_GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (cnt == GAP_END) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cfg_write_sequencer.sv
// Directed bench: SPI frame decoder plus a model of
// the register-file peripheral behind the link.
module tb_spi_cfg_write_sequencer;
  import spi_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [13:0] req_addr = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_ready;
  logic        busy, frame_done, nCS, SCLK, COPI;

  int tests = 0;
  int fails = 0;

  spi_cfg_write_sequencer #(
    .NUM_REQ (2),
    .CLK_DIV (4),
    .CS_GAP  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .busy       (busy),
    .frame_done (frame_done),
    .nCS        (nCS),
    .SCLK       (SCLK),
    .COPI       (COPI)
  );

  always #5 clk = ~clk;

  // Link monitor and peripheral model.
  int          cyc = 0, fall_cyc = 0, rise_cyc = 0;
  int          ncs_low = 0, nbits = 0, last_nbits = 0;
  int          n_grants = 0, n_falls = 0, min_gap = 100000;
  logic        prev_ncs = 1'b1, prev_sclk = 1'b0;
  logic [15:0] rx = '0, last_frame = '0;
  logic [7:0]  regs [5] = '{default: 8'h00};

  always @(negedge clk) begin
    cyc++;
    if (|req_ready) n_grants++;
    if (prev_ncs && !nCS) begin
      n_falls++;
      fall_cyc = cyc;
      nbits = 0;
      if (cyc - rise_cyc < min_gap) min_gap = cyc - rise_cyc;
    end
    if (!prev_ncs && nCS) begin
      ncs_low = cyc - fall_cyc;
      last_nbits = nbits;
      rise_cyc = cyc;
      if (nbits == 16) begin
        last_frame = rx;
        if (rx[15] && rx[14:8] <= MAX_ADDRESS)
          regs[int'(rx[14:8])] = rx[7:0];
      end
    end
    if (!prev_sclk && SCLK && !nCS) begin
      rx = {rx[14:0], COPI};
      nbits++;
    end
    prev_ncs = nCS;
    prev_sclk = SCLK;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v,
                         input logic [6:0] a,
                         input logic [7:0] d);
    req_valid[i] = v;
    req_addr[7*i +: 7] = a;
    req_data[8*i +: 8] = d;
  endtask

  task automatic wait_grant(output int idx, output time t);
    idx = -1;
    t = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (|req_ready) begin
        idx = req_ready[1] ? 1 : 0;
        t = $time;
        break;
      end
    end
    if (idx < 0) chk("grant_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done(output time t);
    t = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (frame_done) begin
        t = $time;
        break;
      end
    end
    if (t == 0) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int          gi, g, rem0, rem1, falls0, grants0;
  time         tg, td;
  int          order [$];
  logic [39:0] snap;

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_outputs",
        {nCS, SCLK, COPI, busy, frame_done, req_ready},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00});
    rst_n = 1'b1;
    @(negedge clk);

    // 1: single write from requester 0
    enable = 1'b1;
    set_req(0, 1'b1, 7'd0, 8'hA5);
    wait_grant(gi, tg);
    set_req(0, 1'b0, 7'd0, 8'h00);
    chk("t1_grant_idx", gi, 0);
    wait_done(td);
    repeat (2) @(negedge clk);
    chk("t1_frame", last_frame, 16'h80A5);
    chk("t1_ncs_low", ncs_low, 132);
    chk("t1_sclk_rises", last_nbits, 16);
    chk("t1_grant_to_done", (td - tg) / 10, 132);
    chk("t1_reg0", regs[0], 8'hA5);

    // 2: both requesters, three frames each
    do_reset();
    rem0 = 3;
    rem1 = 3;
    set_req(0, 1'b1, 7'd2, 8'hB0);
    set_req(1, 1'b1, 7'd3, 8'hC0);
    for (int k = 0; k < 3000 && order.size() < 6; k++) begin
      @(negedge clk);
      if (|req_ready) begin
        g = req_ready[1] ? 1 : 0;
        order.push_back(g);
        if (g == 0) begin
          rem0--;
          set_req(0, rem0 != 0, 7'd2, 8'hB0 + 8'(rem0));
        end else begin
          rem1--;
          set_req(1, rem1 != 0, 7'd3, 8'hC0 + 8'(rem1));
        end
      end
    end
    if (order.size() < 6) chk("t2_timeout", order.size(), 6);
    foreach (order[i]) chk($sformatf("t2_order%0d", i), order[i], i % 2);
    wait_done(td);
    repeat (2) @(negedge clk);
    chk("t2_min_gap_ok", min_gap >= 4, 1'b1);

    // 3: request held while disabled
    enable = 1'b0;
    falls0 = n_falls;
    set_req(1, 1'b1, 7'd4, 8'h80);
    repeat (50) @(negedge clk);
    chk("t3_idle_disabled", {nCS, 32'(n_falls)}, {1'b1, 32'(falls0)});
    enable = 1'b1;
    wait_grant(gi, tg);
    set_req(1, 1'b0, 7'd0, 8'h00);
    chk("t3_grant_idx", gi, 1);
    wait_done(td);
    repeat (2) @(negedge clk);
    chk("t3_frame", last_frame, 16'h8480);
    chk("t3_duty", regs[4], 8'h80);

    // 4: out-of-range address is forwarded but ignored
    snap = {regs[4], regs[3], regs[2], regs[1], regs[0]};
    set_req(0, 1'b1, 7'h05, 8'hFF);
    wait_grant(gi, tg);
    set_req(0, 1'b0, 7'd0, 8'h00);
    wait_done(td);
    repeat (2) @(negedge clk);
    chk("t4_frame", last_frame, 16'h85FF);
    chk("t4_regs_kept", {regs[4], regs[3], regs[2], regs[1], regs[0]}, snap);

    // 5: reset in the middle of a frame
    set_req(0, 1'b1, 7'd1, 8'h3C);
    wait_grant(gi, tg);
    set_req(0, 1'b0, 7'd0, 8'h00);
    for (int k = 0; k < 400 && nbits < 7; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_reset_outs", {nCS, SCLK, busy}, 3'b100);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_commit", regs[1], 8'h00);
    set_req(0, 1'b1, 7'd2, 8'h11);
    set_req(1, 1'b1, 7'd3, 8'h22);
    wait_grant(gi, tg);
    chk("t5_first_grant", gi, 0);

    // 6: enable drops mid-frame with requester 1 pending
    set_req(0, 1'b0, 7'd0, 8'h00);
    repeat (40) @(negedge clk);
    enable = 1'b0;
    wait_done(td);
    repeat (2) @(negedge clk);
    chk("t6_frame", last_frame, 16'h8211);
    chk("t6_reg2", regs[2], 8'h11);
    grants0 = n_grants;
    repeat (50) @(negedge clk);
    chk("t6_no_grant", {nCS, busy, 32'(n_grants)}, {1'b1, 1'b0, 32'(grants0)});
    enable = 1'b1;
    wait_grant(gi, tg);
    set_req(1, 1'b0, 7'd0, 8'h00);
    chk("t6_grant_idx", gi, 1);
    wait_done(td);
    repeat (2) @(negedge clk);
    chk("t6_reg3", regs[3], 8'h22);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
